// File: rtl/align_arbiter.sv
// ---------------------------------------------------------------------------
// align_arbiter
//   Shares one combinational FP16-magnitude alignment unit between NREQ
//   requesters. A round-robin arbiter picks one operand pair per cycle. The
//   pair is ordered into bigger/smaller and registered into stage 1, which
//   drives the shared unit. The unit's aligned mantissa is then captured,
//   together with the request id, into the output stage. The pipeline uses
//   two-stage valid/ready flow control and accepts one pair per cycle.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req_valid/ready per-requester handshake (ready is a one-hot grant)
//   req_a/req_b     packed 15-bit magnitudes {exp[4:0],mant[9:0]}, 15*i+:15
//   al_bigger/      stage-1 operands presented to the shared aligner
//   al_smaller
//   al_aligned      aligner result, combinational from al_bigger/al_smaller
//   out_*           registered result with valid/ready handshake
// ---------------------------------------------------------------------------

// Orders one operand pair by unsigned 15-bit magnitude. Ties keep A.
module align_order (
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic [14:0] bigger,
  output logic [14:0] smaller,
  output logic        swapped
);
  assign swapped = (a < b);
  assign bigger  = swapped ? b : a;
  assign smaller = swapped ? a : b;
endmodule

module align_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*15-1:0]   req_a,
  input  logic [NREQ*15-1:0]   req_b,
  output logic [14:0]          al_bigger,
  output logic [14:0]          al_smaller,
  input  logic [10:0]          al_aligned,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDW-1:0]       out_id,
  output logic [14:0]          out_big,
  output logic [10:0]          out_aligned,
  output logic                 out_swapped
);

  // Unpacked view of the operand buses.
  logic [NREQ-1:0][14:0] op_a, op_b;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a[i] = req_a[15*i +: 15];
    assign op_b[i] = req_b[15*i +: 15];
  end

  // Stage-1 state.
  logic           v1;
  logic [IDW-1:0] id1;
  logic [14:0]    big1, small1;
  logic           sw1;

  logic [IDW-1:0] ptr;

  // Flow control. A stage may load when its current content leaves or is empty.
  logic adv1, adv2;
  assign adv2 = !out_valid | out_ready;
  assign adv1 = !v1 | adv2;

  // Round-robin search starting at ptr.
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  int             idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  // Holding grants off during reset keeps in-flight state from being refilled
  // in the same cycle it is being cleared.
  logic grant_en;
  assign grant_en  = gnt_any & adv1 & !rst;
  assign req_ready = grant_en ? (NREQ'(1) << gnt_id) : '0;

  logic [IDW-1:0] ptr_nxt;
  assign ptr_nxt = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);

  // Order the granted pair.
  logic [14:0] ord_big, ord_small;
  logic        ord_sw;

  align_order u_order (
    .a       (op_a[gnt_id]),
    .b       (op_b[gnt_id]),
    .bigger  (ord_big),
    .smaller (ord_small),
    .swapped (ord_sw)
  );

  assign al_bigger  = big1;
  assign al_smaller = small1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      id1         <= '0;
      big1        <= '0;
      small1      <= '0;
      sw1         <= 1'b0;
      ptr         <= '0;
      out_valid   <= 1'b0;
      out_id      <= '0;
      out_big     <= '0;
      out_aligned <= '0;
      out_swapped <= 1'b0;
    end else begin
      // Stage 1: load a new pair, or go empty when its content moves on.
      if (adv1) begin
        v1 <= grant_en;
        if (grant_en) begin
          id1    <= gnt_id;
          big1   <= ord_big;
          small1 <= ord_small;
          sw1    <= ord_sw;
          ptr    <= ptr_nxt;
        end
      end
      // Output stage: frozen while a result waits for out_ready. The aligner
      // output is valid for the stage-1 pair, so capture it on the same move.
      if (adv2) begin
        out_valid <= v1;
        if (v1) begin
          out_id      <= id1;
          out_big     <= big1;
          out_aligned <= al_aligned;
          out_swapped <= sw1;
        end
      end
    end
  end

endmodule

// File: tb/tb_align_arbiter.sv
// ---------------------------------------------------------------------------
// tb_align_arbiter
//   Directed bench for align_arbiter. Supplies a behavioral model of the
//   shared alignment unit and checks hand-computed results for ordering,
//   alignment, round-robin order, backpressure and reset.
// ---------------------------------------------------------------------------
module tb_align_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*15-1:0] req_a, req_b;
  logic [14:0]       al_bigger, al_smaller;
  logic [10:0]       al_aligned;
  logic              out_valid, out_ready;
  logic [IDW-1:0]    out_id;
  logic [14:0]       out_big;
  logic [10:0]       out_aligned;
  logic              out_swapped;

  int n_tests = 0;
  int n_fail  = 0;

  align_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .al_bigger(al_bigger), .al_smaller(al_smaller), .al_aligned(al_aligned),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_big(out_big), .out_aligned(out_aligned),
    .out_swapped(out_swapped)
  );

  always #5 clk = ~clk;

  // Shared alignment unit model.
  logic [4:0] diff;
  always_comb begin
    diff       = al_bigger[14:10] - al_smaller[14:10];
    al_aligned = {1'b1, al_smaller[9:0]} >> diff;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated pair through the empty pipeline with out_ready=1.
  task automatic send_one(input int idx, input logic [14:0] a, input logic [14:0] b,
                          input logic [14:0] e_big, input logic [10:0] e_al,
                          input logic e_sw, input string tag);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[15*idx +: 15] = a;
    req_b[15*idx +: 15] = b;
    #1;
    check({tag, "_rdy"}, 32'(req_ready), 32'(1 << idx));
    step();
    req_valid = '0;
    check({tag, "_albig"}, 32'(al_bigger), 32'(e_big));
    check({tag, "_v_early"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_id"}, 32'(out_id), 32'(idx));
    check({tag, "_big"}, 32'(out_big), 32'(e_big));
    check({tag, "_aligned"}, 32'(out_aligned), 32'(e_al));
    check({tag, "_swapped"}, 32'(out_swapped), 32'(e_sw));
    step();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  int seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_rdy", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_big", 32'(out_big), 32'd0);
    check("rst_al", 32'(out_aligned), 32'd0);
    check("rst_sw", 32'(out_swapped), 32'd0);
    check("rst_albig", 32'(al_bigger), 32'd0);
    check("rst_alsmall", 32'(al_smaller), 32'd0);
    rst = 1'b0;
    req_valid = '0;
    step();

    // T1..T3: single pairs (pointer ends at 0 afterwards).
    send_one(0, 15'h3C00, 15'h3800, 15'h3C00, 11'h200, 1'b0, "t1");
    send_one(2, 15'h3800, 15'h3C00, 15'h3C00, 11'h200, 1'b1, "t2");
    send_one(1, 15'h4155, 15'h4155, 15'h4155, 11'h555, 1'b0, "t3tie");
    send_one(3, 15'h6C00, 15'h4000, 15'h6C00, 11'h000, 1'b0, "t3d11");

    // T4: all valid, continuous flow; requester i: A=(i+2)<<10, B=(i+1)<<10.
    for (int i = 0; i < NREQ; i++) begin
      req_a[15*i +: 15] = 15'((i + 2) << 10);
      req_b[15*i +: 15] = 15'((i + 1) << 10);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 4'hF : 4'h0;
      #1;
      check($sformatf("t4_rdy%0d", c), 32'(req_ready), (c < 6) ? 32'(1 << seq[c]) : 32'd0);
      if (c < 2) begin
        check($sformatf("t4_v%0d", c), 32'(out_valid), 32'd0);
      end else begin
        check($sformatf("t4_v%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("t4_id%0d", c), 32'(out_id), 32'(seq[c-2]));
        check($sformatf("t4_big%0d", c), 32'(out_big), 32'((seq[c-2] + 2) << 10));
        check($sformatf("t4_al%0d", c), 32'(out_aligned), 32'h200);
      end
      step();
    end
    check("t4_empty", 32'(out_valid), 32'd0);

    // T5: stall with all valid; pointer is at 2.
    out_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    check("t5_rdy0", 32'(req_ready), 32'h4);
    step();
    check("t5_rdy1", 32'(req_ready), 32'h8);
    step();
    check("t5_rdy2", 32'(req_ready), 32'h0);
    check("t5_v2", 32'(out_valid), 32'd1);
    check("t5_id2", 32'(out_id), 32'd2);
    check("t5_big2", 32'(out_big), 32'h1000);
    step();
    check("t5_rdy3", 32'(req_ready), 32'h0);
    check("t5_id3", 32'(out_id), 32'd2);
    check("t5_big3", 32'(out_big), 32'h1000);
    check("t5_al3", 32'(out_aligned), 32'h200);
    step();
    out_ready = 1'b1;
    #1;
    check("t5_rdy4", 32'(req_ready), 32'h1);
    check("t5_id4", 32'(out_id), 32'd2);
    step();
    req_valid = '0;
    check("t5_id5", 32'(out_id), 32'd3);
    check("t5_v5", 32'(out_valid), 32'd1);
    step();
    check("t5_id6", 32'(out_id), 32'd0);
    check("t5_v6", 32'(out_valid), 32'd1);
    step();
    check("t5_v7", 32'(out_valid), 32'd0);

    // T6: fill both stages (pointer at 1), then reset for one cycle.
    out_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    check("t6_rdy0", 32'(req_ready), 32'h2);
    step();
    check("t6_rdy1", 32'(req_ready), 32'h4);
    step();
    check("t6_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rdy_rst", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    req_valid = 4'h0;
    #1;
    check("t6_v", 32'(out_valid), 32'd0);
    check("t6_rdy", 32'(req_ready), 32'h0);
    check("t6_albig", 32'(al_bigger), 32'd0);
    req_valid = 4'hA;
    out_ready = 1'b1;
    #1;
    check("t6_rr0", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    check("t6_nodisc", 32'(out_valid), 32'd0);
    step();
    check("t6_v_after", 32'(out_valid), 32'd1);
    check("t6_id_after", 32'(out_id), 32'd1);
    check("t6_big_after", 32'(out_big), 32'h0C00);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
